// File: rtl/dmem_responder.sv
// Data-side memory responder: word-organised RAM behind a req/ack handshake
// with a fixed number of wait states. busy stalls the pipeline until ack.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]            stateReg, stateNext;
  logic [3:0]            cntReg, cntNext;
  logic [ADDR_WIDTH-1:0] idxReg;
  logic                  oorReg;
  logic [31:0]           wdataReg;
  logic [3:0]            weReg;
  logic [ADDR_WIDTH-1:0] rdIdx;
  logic [31:0]           ramQ;
  logic [3:0]            laneWe;
  logic                  accept;
  logic                  unusedBits;

  assign unusedBits = ^addr[1:0];
  assign accept     = (stateReg == IDLE) && req;

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            stateNext = WAIT;
            cntNext   = WAIT_INIT;
          end else begin
            stateNext = DONE;
          end
        end
      end
      WAIT: begin
        if (cntReg == 4'd0) begin
          stateNext = DONE;
        end else begin
          cntNext = cntReg - 4'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
      idxReg   <= '0;
      oorReg   <= 1'b0;
      wdataReg <= 32'd0;
      weReg    <= 4'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (accept) begin
        idxReg   <= addr[ADDR_WIDTH+1:2];
        oorReg   <= |addr[31:ADDR_WIDTH+2];
        wdataReg <= wdata;
        weReg    <= we;
      end
    end
  end

  // Reading from the live address in IDLE makes the word ready by DONE even
  // with zero wait states; the write lands one edge later (read-before-write).
  assign rdIdx  = (stateReg == IDLE) ? addr[ADDR_WIDTH+1:2] : idxReg;
  assign laneWe = {4{!rst && (stateReg == DONE) && !oorReg}} & weReg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH];
      logic [7:0] laneQ;
      always_ff @(posedge clk) begin
        if (laneWe[gi]) begin
          laneMem[idxReg] <= wdataReg[8*gi +: 8];
        end
        laneQ <= laneMem[rdIdx];
      end
      assign ramQ[8*gi +: 8] = laneQ;
    end
  endgenerate

  assign busy  = accept || (stateReg == WAIT);
  assign ack   = (stateReg == DONE);
  assign err   = (stateReg == DONE) && oorReg;
  assign rdata = ((stateReg == DONE) && !oorReg) ? ramQ : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a
// zero-wait instance sharing the address/data/enable stimulus.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst, req, zReq;
  logic [31:0] addr, wdata;
  logic [3:0]  we;
  logic        busy, ack, err, zBusy, zAck, zErr;
  logic [31:0] rdata, zRdata;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .we(we),
    .busy(busy), .ack(ack), .rdata(rdata), .err(err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) zdut (
    .clk(clk), .rst(rst), .req(zReq), .addr(addr), .wdata(wdata), .we(we),
    .busy(zBusy), .ack(zAck), .rdata(zRdata), .err(zErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on the selected instance; returns ack-cycle data and the
  // number of cycles from request to ack. Inputs are scrambled during WAIT.
  task automatic xact(input bit sel, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, output logic [31:0] rd, output logic e,
                      output int lat);
    int busyCnt;
    bit got;
    @(posedge clk); #1;
    addr = a; we = w; wdata = d;
    if (sel) zReq = 1'b1; else req = 1'b1;
    lat = 0; busyCnt = 0; got = 1'b0; rd = '0; e = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk);
      if (sel ? zAck : ack) begin
        got = 1'b1;
        rd  = sel ? zRdata : rdata;
        e   = sel ? zErr : err;
        check("busyAtAck", 32'(sel ? zBusy : busy), 32'd0);
      end else begin
        if (sel ? zBusy : busy) busyCnt++;
        if (lat > 0) begin
          addr = ~a; we = ~w; wdata = ~d;
        end
        lat++;
      end
    end
    check("ackSeen", 32'(got), 32'd1);
    check("busyCycles", 32'(busyCnt), 32'(lat));
    @(posedge clk); #1;
    req = 1'b0; zReq = 1'b0;
    @(negedge clk);
    check("ackPulse", 32'(sel ? zAck : ack), 32'd0);
    $display("xact sel=%0d addr=%h we=%b wdata=%h -> rdata=%h err=%0d lat=%0d",
             sel, a, w, d, rd, e, lat);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  bit          sawAck, sawBusy;
  int          acks, first, second, n, a1, a2;

  initial begin
    rst = 1'b1; req = 1'b0; zReq = 1'b0; addr = '0; we = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstAck", 32'(ack), 32'd0);
    check("rstErr", 32'(err), 32'd0);
    check("rstRdata", rdata, 32'd0);
    check("rstZAck", 32'(zAck), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Word store then load
    xact(0, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat);
    check("t1StLat", 32'(lat), 32'd3);
    check("t1StErr", 32'(e), 32'd0);
    xact(0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    check("t1LdData", rd, 32'hDEADBEEF);
    check("t1LdErr", 32'(e), 32'd0);
    check("t1LdLat", 32'(lat), 32'd3);

    // Byte merge; the store ack shows the old word
    xact(0, 32'h12, 4'b0100, 32'h00AA0000, rd, e, lat);
    check("t2StOld", rd, 32'hDEADBEEF);
    xact(0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    check("t2LdMerge", rd, 32'hDEAABEEF);

    // Out of range store aliasing word 0 must not write it
    xact(0, 32'h0, 4'hF, 32'h12345678, rd, e, lat);
    xact(0, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, e, lat);
    check("t3OorErr", 32'(e), 32'd1);
    check("t3OorData", rd, 32'd0);
    check("t3OorLat", 32'(lat), 32'd3);
    xact(0, 32'h0, 4'h0, 32'h0, rd, e, lat);
    check("t3LdWord0", rd, 32'h12345678);
    check("t3LdErr", 32'(e), 32'd0);

    // Reset while in WAIT discards the store
    xact(0, 32'h20, 4'hF, 32'h11111111, rd, e, lat);
    @(posedge clk); #1;
    addr = 32'h20; we = 4'hF; wdata = 32'h22222222; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    check("t4BusyWait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sawAck = 1'b0; sawBusy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sawAck  = sawAck | ack;
      sawBusy = sawBusy | busy;
    end
    check("t4NoAck", 32'(sawAck), 32'd0);
    check("t4NoBusy", 32'(sawBusy), 32'd0);
    xact(0, 32'h20, 4'h0, 32'h0, rd, e, lat);
    check("t4LdOld", rd, 32'h11111111);

    // Zero-wait instance
    xact(1, 32'h40, 4'hF, 32'hA5A5A5A5, rd, e, lat);
    check("t5StLat", 32'(lat), 32'd1);
    xact(1, 32'h40, 4'h0, 32'h0, rd, e, lat);
    check("t5LdLat", 32'(lat), 32'd1);
    check("t5LdData", rd, 32'hA5A5A5A5);
    @(posedge clk); #1;
    addr = 32'h40; we = 4'h0; zReq = 1'b1;
    acks = 0; first = -1; second = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (zAck) begin
        acks++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    @(posedge clk); #1 zReq = 1'b0;
    check("t5Acks", 32'(acks), 32'd5);
    check("t5First", 32'(first), 32'd1);
    check("t5Gap", 32'(second - first), 32'd2);

    // Back-to-back with new request presented in the DONE cycle
    @(posedge clk); #1;
    addr = 32'h30; we = 4'hF; wdata = 32'hCAFEF00D; req = 1'b1;
    n = 0; a1 = -1; a2 = -1; rd = '0;
    while (a2 < 0 && n < 30) begin
      @(negedge clk);
      if (ack) begin
        if (a1 < 0) begin
          a1 = n; addr = 32'h10; we = 4'h0; wdata = 32'h0;
        end else begin
          a2 = n; rd = rdata;
        end
      end
      n++;
    end
    @(posedge clk); #1 req = 1'b0;
    $display("b2b first ack=%0d second ack=%0d rdata=%h", a1, a2, rd);
    check("t6FirstAck", 32'(a1), 32'd3);
    check("t6Gap", 32'(a2 - a1), 32'd4);
    check("t6SecondData", rd, 32'hDEAABEEF);
    xact(0, 32'h30, 4'h0, 32'h0, rd, e, lat);
    check("t6LdFirst", rd, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
